// File: rtl/dap_baud_arbiter_if.sv
// dap_baud_arbiter_if: requester handshake plus the baud generator register write port
interface dap_baud_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int ADDRWIDTH = 12
);
  logic [NREQ-1:0] req;
  logic [16*NREQ-1:0] req_div;
  logic [3*NREQ-1:0] req_delay;
  logic [NREQ-1:0] gnt;
  logic busy;
  logic [IDW-1:0] active_id;
  logic bg_write_en;
  logic [ADDRWIDTH-1:0] bg_addr;
  logic [31:0] bg_wdata;
  logic [3:0] bg_byte_strobe;
  modport master (
    input req, req_div, req_delay,
    output gnt, busy, active_id, bg_write_en, bg_addr, bg_wdata, bg_byte_strobe
  );
  modport slave (
    output req, req_div, req_delay,
    input gnt, busy, active_id, bg_write_en, bg_addr, bg_wdata, bg_byte_strobe
  );
endinterface

// File: rtl/dap_baud_arbiter.sv
// dap_baud_arbiter: round-robin sharing of the DAP baud generator between protocol engines
module dap_baud_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int ADDRWIDTH = 12,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR = '0,
  parameter int SETTLE_CYCLES = 8
) (
  input logic clk,
  input logic resetn,
  dap_baud_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR_TIM, WR_EN, SETTLE, GRANTED, RELEASE} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, pick, cand;
  logic [15:0] div_q, div_d;
  logic [2:0] dly_q, dly_d;
  logic [7:0] cnt_q, cnt_d;
  logic [15:0] div_a [NREQ];
  logic [2:0] dly_a [NREQ];
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic busy_q, we_q, we_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0] strb_q, strb_d;
  for (genvar i = 0; i < NREQ; i++) begin : g_cfg
    assign div_a[i] = bus.req_div[16*i +: 16];
    assign dly_a[i] = bus.req_delay[3*i +: 3];
  end
  // descending scan so the nearest requester after the pointer wins
  always_comb begin
    pick = ptr_q;
    cand = ptr_q;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (bus.req[cand]) pick = cand;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q <= IDW'(NREQ - 1);
      id_q <= '0;
      div_q <= '0;
      dly_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      busy_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= BASE_ADDR;
      wdata_q <= '0;
      strb_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      div_q <= div_d;
      dly_q <= dly_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      busy_q <= state_d != IDLE;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      strb_q <= strb_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    div_d = div_q;
    dly_d = dly_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d = WR_TIM;
        id_d = pick;
        div_d = div_a[pick];
        dly_d = dly_a[pick];
      end
      WR_TIM: state_d = WR_EN;
      WR_EN: begin
        state_d = SETTLE;
        cnt_d = 8'(SETTLE_CYCLES - 1);
      end
      SETTLE: if (!bus.req[id_q]) state_d = RELEASE;
        else if (cnt_q == 8'd0) state_d = GRANTED;
        else cnt_d = cnt_q - 8'd1;
      GRANTED: if (!bus.req[id_q]) state_d = RELEASE;
      RELEASE: begin
        state_d = IDLE;
        ptr_d = id_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are precomputed from the next state so the registers line up with it
  always_comb begin
    we_d = state_d inside {WR_TIM, WR_EN, RELEASE};
    addr_d = (state_d == WR_TIM) ? BASE_ADDR + ADDRWIDTH'(4) : BASE_ADDR;
    wdata_d = (state_d == WR_TIM) ? {13'd0, dly_d, div_d} : (state_d == WR_EN) ? 32'd1 : 32'd0;
    strb_d = (state_d == WR_TIM) ? 4'b0111 : we_d ? 4'b0001 : 4'b0000;
    gnt_d = (state_d == GRANTED) ? NREQ'(1) << id_d : '0;
  end
  assign bus.gnt = gnt_q;
  assign bus.busy = busy_q;
  assign bus.active_id = id_q;
  assign bus.bg_write_en = we_q;
  assign bus.bg_addr = addr_q;
  assign bus.bg_wdata = wdata_q;
  assign bus.bg_byte_strobe = strb_q;
endmodule

// File: tb/tb_dap_baud_arbiter.sv
// tb_dap_baud_arbiter: randomized scoreboard bench against a transaction-level timing model
module tb_dap_baud_arbiter;
  localparam int N = 2;
  localparam int IW = 1;
  localparam int S = 8;
  localparam int EV_GNT = 0;
  localparam int EV_BUSY = 1;
  localparam int EV_WR = 2;
  typedef struct packed {
    int kind;
    int cyc;
    logic [N-1:0] gnt;
    logic busy;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [IW-1:0] aid;
  } ev_t;
  logic clk, resetn;
  int cyc, n_cmp, n_bad;
  bit mon_en;
  logic [N-1:0] r;
  logic [N-1:0][15:0] tdv;
  logic [N-1:0][2:0] tdl;
  logic [N-1:0] p_gnt;
  logic p_busy;
  ev_t q[$];
  bit m_act, m_gr;
  int m_k, m_id, m_ptr, m_free;
  dap_baud_arbiter_if #(.NREQ(N), .ADDRWIDTH(12)) bus ();
  dap_baud_arbiter #(.NREQ(N), .ADDRWIDTH(12), .SETTLE_CYCLES(S)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  function automatic ev_t mk(int k, int c, logic [N-1:0] g, logic b, logic [11:0] a, logic [31:0] d, logic [3:0] s, logic [IW-1:0] id);
    ev_t e;
    e.kind = k; e.cyc = c; e.gnt = g; e.busy = b; e.addr = a; e.data = d; e.strb = s; e.aid = id;
    return e;
  endfunction
  function automatic int rr_pick(logic [N-1:0] rq, int p);
    for (int i = 1; i <= N; i++) if (rq[IW'((p + i) % N)]) return (p + i) % N;
    return -1;
  endfunction
  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic pop_cmp(string n, ev_t got);
    ev_t exp;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got kind=%0d cyc=%0d gnt=%b busy=%b addr=%h data=%h strb=%b id=%0d, expected no event",
               n, got.kind, got.cyc, got.gnt, got.busy, got.addr, got.data, got.strb, got.aid);
      return;
    end
    exp = q.pop_front();
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got kind=%0d cyc=%0d gnt=%b busy=%b addr=%h data=%h strb=%b id=%0d, expected kind=%0d cyc=%0d gnt=%b busy=%b addr=%h data=%h strb=%b id=%0d",
               n, got.kind, got.cyc, got.gnt, got.busy, got.addr, got.data, got.strb, got.aid,
               exp.kind, exp.cyc, exp.gnt, exp.busy, exp.addr, exp.data, exp.strb, exp.aid);
    end
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (bus.gnt !== p_gnt) pop_cmp("gnt_edge", mk(EV_GNT, cyc, bus.gnt, 1'b0, '0, '0, '0, '0));
        if (bus.busy !== p_busy) pop_cmp("busy_edge", mk(EV_BUSY, cyc, '0, bus.busy, '0, '0, '0, '0));
        if (bus.bg_write_en !== 1'b0) pop_cmp("bg_write", mk(EV_WR, cyc, '0, 1'b0, bus.bg_addr, bus.bg_wdata, bus.bg_byte_strobe, bus.active_id));
      end
      p_gnt = bus.gnt;
      p_busy = bus.busy;
    end
  end
  // predicts every observable event for a clock edge e from the request levels driven for it
  task automatic model_edge(int e);
    int p;
    if (!m_act) begin
      p = rr_pick(r, m_ptr);
      if (p >= 0 && e >= m_free) begin
        m_act = 1; m_gr = 0; m_k = e; m_id = p;
        q.push_back(mk(EV_BUSY, e, '0, 1'b1, '0, '0, '0, '0));
        q.push_back(mk(EV_WR, e, '0, 1'b0, 12'h004, {13'd0, tdl[IW'(p)], tdv[IW'(p)]}, 4'b0111, IW'(p)));
        q.push_back(mk(EV_WR, e + 1, '0, 1'b0, 12'h000, 32'd1, 4'b0001, IW'(p)));
      end
    end else if (e >= m_k + 3) begin
      if (!r[IW'(m_id)]) begin
        if (m_gr) q.push_back(mk(EV_GNT, e, '0, 1'b0, '0, '0, '0, '0));
        q.push_back(mk(EV_WR, e, '0, 1'b0, 12'h000, 32'd0, 4'b0001, IW'(m_id)));
        q.push_back(mk(EV_BUSY, e + 1, '0, 1'b0, '0, '0, '0, '0));
        m_act = 0; m_ptr = m_id; m_free = e + 2;
      end else if (!m_gr && e == m_k + 2 + S) begin
        q.push_back(mk(EV_GNT, e, N'(1) << m_id, 1'b0, '0, '0, '0, '0));
        m_gr = 1;
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    bus.req = r;
    bus.req_div = tdv;
    bus.req_delay = tdl;
    model_edge(cyc + 1);
  endtask
  task automatic hold(int n);
    repeat (n) step();
  endtask
  task automatic chk_reset(string n);
    chk({n, "_gnt"}, 64'(bus.gnt), 64'd0);
    chk({n, "_busy"}, 64'(bus.busy), 64'd0);
    chk({n, "_active_id"}, 64'(bus.active_id), 64'd0);
    chk({n, "_bg_write_en"}, 64'(bus.bg_write_en), 64'd0);
    chk({n, "_bg_addr"}, 64'(bus.bg_addr), 64'd0);
    chk({n, "_bg_wdata"}, 64'(bus.bg_wdata), 64'd0);
    chk({n, "_bg_byte_strobe"}, 64'(bus.bg_byte_strobe), 64'd0);
  endtask
  task automatic do_reset(string n);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 mon_en = 0;
    chk_reset(n);
    q.delete();
    m_act = 0; m_gr = 0; m_ptr = N - 1; m_free = 0;
    r = '0;
    bus.req = '0;
    @(negedge clk);
    resetn = 1'b1;
    mon_en = 1;
  endtask
  initial begin
    resetn = 1'b0;
    mon_en = 0;
    n_cmp = 0; n_bad = 0; cyc = 0;
    r = '0; tdv = '0; tdl = '0;
    bus.req = '0; bus.req_div = '0; bus.req_delay = '0;
    p_gnt = '0; p_busy = 1'b0;
    m_act = 0; m_gr = 0; m_ptr = N - 1; m_free = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk);
    resetn = 1'b1;
    mon_en = 1;
    r = 2'b01; tdv[0] = 16'h0004; tdl[0] = 3'd3;
    hold(20);
    r = '0;
    hold(5);
    do_reset("reset2");
    r = 2'b11; tdv[1] = 16'h1234; tdl[1] = 3'd5;
    hold(20);
    r[0] = 1'b0;
    hold(1);
    r[0] = 1'b1;
    hold(20);
    r[1] = 1'b0;
    hold(20);
    r[0] = 1'b0;
    hold(5);
    r[1] = 1'b1;
    hold(5);
    r[1] = 1'b0;
    hold(6);
    r[0] = 1'b1; tdv[0] = 16'h0100; tdl[0] = 3'd1;
    hold(15);
    tdv[0] = 16'h0200; tdl[0] = 3'd6;
    hold(10);
    r[0] = 1'b0;
    hold(4);
    r[0] = 1'b1;
    hold(15);
    r[0] = 1'b0;
    hold(4);
    r[0] = 1'b1;
    hold(6);
    do_reset("reset_mid_settle");
    r = 2'b11;
    hold(20);
    r = '0;
    hold(5);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!r[IW'(i)]) begin
          if ($urandom_range(0, 9) == 0) begin
            r[IW'(i)] = 1'b1;
            tdv[IW'(i)] = 16'($urandom);
            tdl[IW'(i)] = 3'($urandom);
          end
        end else if ($urandom_range(0, 24) == 0) r[IW'(i)] = 1'b0;
        else if ($urandom_range(0, 7) == 0) tdv[IW'(i)] = 16'($urandom);
      end
      step();
    end
    r = '0;
    hold(20);
    @(posedge clk);
    #2 chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
